// File: rtl/adbg_core_run_ctrl.sv
// Multi-core run control: carries HALT/RESUME/RESET from TCK to the cores over a toggle
// handshake, latches breakpoints with group cross-triggering and returns per-core status.
module adbg_core_run_ctrl #(
   parameter int NB_CORES         = 4,
   parameter int RST_PULSE_CYCLES = 16,
   parameter int SYNC_STAGES      = 2
) (
   input  logic                    cpu_clk_i,
   input  logic                    cpu_rstn_i,
   input  logic                    tck_i,
   input  logic                    tlr_i,
   input  logic                    cmd_valid_i,
   input  logic [1:0]              cmd_i,
   input  logic [NB_CORES-1:0]     cmd_mask_i,
   output logic                    cmd_busy_o,
   input  logic [NB_CORES-1:0]     xtrig_en_i,
   output logic [3*NB_CORES-1:0]   status_o,
   input  logic [NB_CORES-1:0]     bp_i,
   output logic [NB_CORES-1:0]     cpu_stall_o,
   output logic [NB_CORES-1:0]     cpu_rst_o
);

   localparam logic [1:0] CMD_HALT   = 2'b01;
   localparam logic [1:0] CMD_RESUME = 2'b10;
   localparam logic [1:0] CMD_RESET  = 2'b11;
   localparam int CNT_W = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;

   typedef enum logic {ST_IDLE, ST_RST} state_e;

   // TCK domain
   logic [1:0]                              cmd_q;
   logic [NB_CORES-1:0]                     mask_q;
   logic                                    req_tgl_q;
   logic                                    busy_q;
   logic [SYNC_STAGES-1:0]                  ack_sync_q;
   logic [SYNC_STAGES-1:0][3*NB_CORES-1:0]  status_sync_q;

   // CPU domain
   logic [SYNC_STAGES-1:0]                  req_sync_q;
   logic [SYNC_STAGES-1:0][NB_CORES-1:0]    xtrig_sync_q;
   state_e                                  state_q, state_d;
   logic [CNT_W-1:0]                        cnt_q, cnt_d;
   logic                                    ack_tgl_q, ack_tgl_d;
   logic [NB_CORES-1:0]                     rst_q, rst_d;
   logic [NB_CORES-1:0]                     host_stall_q, host_stall_d;
   logic [NB_CORES-1:0]                     stall_bp_q, stall_bp_d;
   logic [NB_CORES-1:0]                     bp_hit_q, bp_hit_d;
   logic [NB_CORES-1:0]                     stall_q;
   logic [NB_CORES-1:0]                     xtrig, bp_set, clr;
   logic                                    any_grp, pending;
   logic [3*NB_CORES-1:0]                   status_cpu;

   always_ff @(posedge tck_i or posedge tlr_i) begin
      if (tlr_i) begin
         cmd_q         <= '0;
         mask_q        <= '0;
         req_tgl_q     <= 1'b0;
         busy_q        <= 1'b0;
         ack_sync_q    <= '0;
         status_sync_q <= '0;
      end else begin
         ack_sync_q    <= {ack_sync_q[SYNC_STAGES-2:0], ack_tgl_q};
         status_sync_q <= {status_sync_q[SYNC_STAGES-2:0], status_cpu};
         if (!busy_q && cmd_valid_i) begin
            cmd_q     <= cmd_i;
            mask_q    <= cmd_mask_i;
            req_tgl_q <= ~req_tgl_q;
            busy_q    <= 1'b1;
         end else if (busy_q && (ack_sync_q[SYNC_STAGES-1] == req_tgl_q)) begin
            busy_q    <= 1'b0;
         end
      end
   end

   assign cmd_busy_o = busy_q;
   assign status_o   = status_sync_q[SYNC_STAGES-1];

   always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
      if (!cpu_rstn_i) begin
         req_sync_q   <= '0;
         xtrig_sync_q <= '0;
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         ack_tgl_q    <= 1'b0;
         rst_q        <= '0;
         host_stall_q <= '0;
         stall_bp_q   <= '0;
         bp_hit_q     <= '0;
         stall_q      <= '0;
      end else begin
         req_sync_q   <= {req_sync_q[SYNC_STAGES-2:0], req_tgl_q};
         xtrig_sync_q <= {xtrig_sync_q[SYNC_STAGES-2:0], xtrig_en_i};
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ack_tgl_q    <= ack_tgl_d;
         rst_q        <= rst_d;
         host_stall_q <= host_stall_d;
         stall_bp_q   <= stall_bp_d;
         bp_hit_q     <= bp_hit_d;
         stall_q      <= cpu_stall_o;
      end
   end

   always_comb begin
      xtrig        = xtrig_sync_q[SYNC_STAGES-1];
      pending      = req_sync_q[SYNC_STAGES-1] ^ ack_tgl_q;
      any_grp      = |(bp_i & xtrig);
      bp_set       = bp_i | (xtrig & {NB_CORES{any_grp}});
      state_d      = state_q;
      cnt_d        = cnt_q;
      ack_tgl_d    = ack_tgl_q;
      rst_d        = rst_q;
      host_stall_d = host_stall_q;
      clr          = '0;
      case (state_q)
         ST_IDLE: begin
            if (pending) begin
               case (cmd_q)
                  CMD_HALT: begin
                     host_stall_d = host_stall_q | mask_q;
                     ack_tgl_d    = ~ack_tgl_q;
                  end
                  CMD_RESUME: begin
                     host_stall_d = host_stall_q & ~mask_q;
                     clr          = mask_q;
                     ack_tgl_d    = ~ack_tgl_q;
                  end
                  CMD_RESET: begin
                     rst_d   = mask_q;
                     clr     = mask_q;
                     cnt_d   = CNT_W'(RST_PULSE_CYCLES - 1);
                     state_d = ST_RST;
                  end
                  default: ack_tgl_d = ~ack_tgl_q;
               endcase
            end
         end
         default: begin
            if (cnt_q == '0) begin
               rst_d     = '0;
               ack_tgl_d = ~ack_tgl_q;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
      endcase
      // A breakpoint beats a same-cycle clear, but is masked while the core is held in reset.
      stall_bp_d = (stall_bp_q & ~clr) | (bp_set & ~(rst_q | rst_d));
      bp_hit_d   = (bp_hit_q & ~clr) | (bp_i & ~(rst_q | rst_d));
   end

   assign cpu_stall_o = bp_set | stall_bp_q | host_stall_q;
   assign cpu_rst_o   = rst_q;

   for (genvar gi = 0; gi < NB_CORES; gi++) begin : g_status
      assign status_cpu[3*gi +: 3] = {rst_q[gi], bp_hit_q[gi], stall_q[gi]};
   end

endmodule

// File: doc/adbg_core_run_ctrl.md
# adbg_core_run_ctrl

Multi-core run-control block for the debug unit. It carries halt, resume and timed-reset commands from the JTAG (TCK) domain to NB_CORES CPUs using a toggle request/acknowledge handshake. It also latches breakpoints with optional cross-triggering inside a core group, and returns per-core status to TCK. It sits between the debug module's command decoder and the cores' stall and reset inputs.

## Interface
- NB_CORES, 4: number of controlled cores (1..32).
- RST_PULSE_CYCLES, 16: cpu_clk_i cycles that cpu_rst_o stays asserted per reset command (≥1).
- SYNC_STAGES, 2: flops in every synchroniser chain (≥2).
- cpu_clk_i  in  1  CPU clock.
- cpu_rstn_i  in  1  asynchronous, active-low reset of all cpu_clk_i flops. It must not be driven from cpu_rst_o.
- tck_i  in  1  JTAG clock.
- tlr_i  in  1  asynchronous, active-high reset of all tck_i flops (Test-Logic-Reset).
- cmd_valid_i  in  1  TCK: command strobe.
- cmd_i  in  2  TCK: 00 NOP, 01 HALT, 10 RESUME, 11 RESET.
- cmd_mask_i  in  NB_CORES  TCK: target cores.
- cmd_busy_o  out  1  TCK: command in flight.
- xtrig_en_i  in  NB_CORES  TCK: cross-trigger group membership; quasi-static, synchronised per bit.
- status_o  out  3*NB_CORES  TCK: bits [3i+2:3i] = {in_reset, bp_hit, stalled} of core i, synchronised.
- bp_i  in  NB_CORES  CPU: breakpoint/trap, level.
- cpu_stall_o  out  NB_CORES  CPU: stall request.
- cpu_rst_o  out  NB_CORES  CPU: core reset, active-high.

## Operation
- TCK side: a command is accepted when cmd_valid_i=1 and cmd_busy_o=0.
  - Acceptance captures cmd_i/cmd_mask_i into cmd_q/mask_q, flips req_tgl and sets busy.
  - cmd_valid_i while busy is ignored.
  - Busy clears when the synchronised ack_tgl equals req_tgl.
  - tlr_i clears cmd_q, mask_q, req_tgl, busy and the status synchronisers.
- CPU side: req_tgl is synchronised into the CPU domain.
  - A pending command is defined as req_sync != ack_tgl.
  - cmd_q/mask_q are sampled only in the cycle the pending command is detected; they are stable by construction.
- CPU FSM has two states, IDLE and RST.
  - IDLE, pending NOP, HALT or RESUME: apply the command, flip ack_tgl and stay in IDLE.
  - IDLE, pending RESET: assert rst_q for masked cores, load cnt=RST_PULSE_CYCLES-1 and go to RST.
  - RST: cnt decrements each cycle. At cnt=0, clear rst_q, flip ack_tgl and go to IDLE.
- HALT sets host_stall[i] for each masked core.
- RESUME clears host_stall[i], stall_bp[i] and bp_hit[i] for each masked core.
- RESET pulse: clears stall_bp and bp_hit of masked cores at the pulse start. host_stall is preserved, so a core can be reset into the halted state.
- Breakpoint latching:
  - any_grp = OR over j of (bp_i[j] & xtrig_sync[j]).
  - stall_bp[i] sets on bp_i[i] | (xtrig_sync[i] & any_grp).
  - bp_hit[i] sets only on bp_i[i], so it identifies the originating core.
- cpu_stall_o[i] = bp_i[i] | (xtrig_sync[i] & any_grp) | stall_bp[i] | host_stall[i]. The combinational terms give a same-cycle stall.
- cpu_rst_o[i] = rst_q[i], driven from a flop.
- Status: status_cpu[i] = {rst_q[i], bp_hit[i], cpu_stall_o[i] registered}. It passes SYNC_STAGES flops into TCK. Individual bits are independent and not coherent as a word.
- Simultaneous events:
  - bp_i[i] in the same cycle as a RESUME of core i: the breakpoint wins, so stall_bp and bp_hit end set.
  - bp_i[i] during an active reset pulse on core i: ignored.

## Timing
- Reset values:
  - cpu_stall_o=0, cpu_rst_o=0, cmd_busy_o=0, status_o=0.
  - FSM=IDLE, cnt=0, ack_tgl=0.
- Command latency:
  - HALT/RESUME takes effect SYNC_STAGES+1 cpu_clk_i edges after the accepting tck_i edge.
  - RESET asserts cpu_rst_o at that same edge and holds it exactly RESET_PULSE_CYCLES edges.
  - cmd_busy_o falls SYNC_STAGES+1 tck_i edges after the ack flip.
- cpu_rstn_i asserted mid-command: CPU state clears and ack_tgl becomes 0.
  - If req_tgl=1, the command re-executes once after reset release. This is harmless: HALT/RESUME are idempotent and RESET re-pulses.
  - cpu_rst_o drops immediately.
- tlr_i asserted mid-command: req_tgl returns to 0 with cmd_q=NOP. The CPU side executes at most one NOP and flips ack, and no state changes.
- xtrig_en_i changes take effect SYNC_STAGES cpu cycles later. They must not be changed while any bp is pending.

## Test plan
- HALT, mask 4'b0101, SYNC_STAGES=2 → cpu_stall_o=4'b0101 on cpu edge 3. cmd_busy_o is high for about 6 tck cycles, then status_o stalled bits read 1,0,1,0.
- bp_i[2] pulsed 1 cycle with xtrig_en=4'b0110 → cpu_stall_o=4'b0110 in the same cycle and latched. bp_hit is set only for core 2. RESUME mask 4'b0110 clears all of it.
- RESET, mask 4'b1000, RST_PULSE_CYCLES=16 → cpu_rst_o[3] high for exactly 16 cpu cycles. host_stall is kept; stall_bp[3] and bp_hit[3] are cleared. Busy falls after the ack returns.
- RESUME of core 1 with bp_i[1]=1 in the execute cycle → stall_bp[1]=1, bp_hit[1]=1.
- cpu_rstn_i low during the RESET pulse → cpu_rst_o=0 at once. After release the pulse repeats a full 16 cycles and busy then clears.
- tlr_i during busy → busy=0 and status_o=0 immediately. The CPU side sees a single NOP and outputs are unchanged.
